controlador_cache: RTL and testbench

- Sequencing controller for the 2-way set-associative write-back cache (4-bit address: tag = addr[3:2], index = addr[1:0]; 8-bit data).
- Accepts one CPU request at a time over a req/ack handshake and probes the cache.
- On a miss it runs the miss sequence against a slow backing memory over a req/ack handshake: write back the dirty victim, fetch the line, fill the cache.
- Keeps saturating hit, miss and writeback counters for the board LEDs/displays.

---
 rtl/controlador_cache.sv | 212 +++++++++++++++++++++
 tb/tb_controlador_cache.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_cache.sv
// Sequencing controller for a 2-way set-associative write-back cache: one CPU request at a time, probe, then writeback/fetch/fill on a miss.
// Latency: hit 3 cycles, clean miss 4 + fetch wait, dirty miss 5 + writeback wait + fetch wait (cycles counted from the request cycle to the ack cycle).
// Backpressure: cpu_req is only sampled in IDLE; mem_req is held until mem_ack or until TIMEOUT cycles pass, which aborts the request with cpu_err.
//
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   cpu_*                 - CPU request (req/wr/addr/wdata) and response (ack/rdata/hit/err)
//   c_*                   - cache probe (lookup/addr -> hit/rdata/victim info) and update (write/fill)
//   mem_*                 - backing-memory req/ack handshake for writeback and fetch
//   n_hit, n_miss, n_wb   - saturating statistics counters
module controlador_cache #(
  parameter int ADDR_W  = 4,
  parameter int IDX_W   = 2,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ack,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_hit,
  output logic                    cpu_err,
  output logic                    c_lookup,
  output logic [ADDR_W-1:0]       c_addr,
  input  logic                    c_hit,
  input  logic [DATA_W-1:0]       c_rdata,
  input  logic                    c_vdirty,
  input  logic [ADDR_W-IDX_W-1:0] c_vtag,
  input  logic [DATA_W-1:0]       c_vdata,
  output logic                    c_write,
  output logic                    c_fill,
  output logic                    c_fill_dirty,
  output logic [DATA_W-1:0]       c_wdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [CNT_W-1:0]        n_hit,
  output logic [CNT_W-1:0]        n_miss,
  output logic [CNT_W-1:0]        n_wb
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_FETCH, S_FILL, S_RESPOND
  } state_t;

  state_t r_state, w_state_nxt;

  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_c_wdata;
  logic                r_c_write;
  logic                r_cpu_ack, r_cpu_hit, r_cpu_err;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [TMO_W-1:0]    r_tmo;
  logic [CNT_W-1:0]    r_n_hit, r_n_miss, r_n_wb;

  logic w_mem_done;
  logic w_tmo;

  // An ack is only honoured while the request is actually up, so the one-cycle
  // gap between writeback and fetch cannot complete the fetch early.
  assign w_mem_done = r_mem_req & mem_ack;
  // Ack in the last allowed cycle wins over the timeout.
  assign w_tmo      = r_mem_req & ~mem_ack & (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (cpu_req) w_state_nxt = S_LOOKUP;
      S_LOOKUP:    if (c_hit)         w_state_nxt = S_RESPOND;
                   else if (c_vdirty) w_state_nxt = S_WRITEBACK;
                   else               w_state_nxt = S_FETCH;
      S_WRITEBACK: if (w_mem_done)    w_state_nxt = S_FETCH;
                   else if (w_tmo)    w_state_nxt = S_IDLE;
      S_FETCH:     if (w_mem_done)    w_state_nxt = S_FILL;
                   else if (w_tmo)    w_state_nxt = S_IDLE;
      S_FILL:      w_state_nxt = S_RESPOND;
      S_RESPOND:   w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_c_wdata   <= '0;
      r_c_write   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_hit   <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tmo       <= '0;
      r_n_hit     <= '0;
      r_n_miss    <= '0;
      r_n_wb      <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_c_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_wr    <= cpu_wr;
            r_wdata <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          r_tmo <= '0;
          if (c_hit) begin
            // Ack is registered so it is high during RESPOND; c_write also lands
            // in RESPOND so it never overlaps c_lookup.
            r_cpu_ack   <= 1'b1;
            r_cpu_hit   <= 1'b1;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= r_wr ? r_wdata : c_rdata;
            if (r_wr) begin
              r_c_write <= 1'b1;
              r_c_wdata <= r_wdata;
            end
            if (r_n_hit != {CNT_W{1'b1}}) r_n_hit <= r_n_hit + CNT_W'(1);
          end else begin
            if (r_n_miss != {CNT_W{1'b1}}) r_n_miss <= r_n_miss + CNT_W'(1);
            r_mem_req <= 1'b1;
            if (c_vdirty) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {c_vtag, r_addr[IDX_W-1:0]};
              r_mem_wdata <= c_vdata;
            end else begin
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_addr;
            end
          end
        end
        S_WRITEBACK, S_FETCH: begin
          if (!r_mem_req) begin
            // Gap cycle after a writeback: raise the fetch request now.
            r_mem_req <= 1'b1;
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_tmo     <= '0;
            if (r_state == S_WRITEBACK) begin
              if (r_n_wb != {CNT_W{1'b1}}) r_n_wb <= r_n_wb + CNT_W'(1);
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_addr;
            end else begin
              // Write-allocate: a write miss fills with the CPU data, not memory's.
              r_c_wdata <= r_wr ? r_wdata : mem_rdata;
            end
          end else if (w_tmo) begin
            r_mem_req <= 1'b0;
            r_cpu_ack <= 1'b1;
            r_cpu_hit <= 1'b0;
            r_cpu_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_FILL: begin
          r_cpu_ack   <= 1'b1;
          r_cpu_hit   <= 1'b0;
          r_cpu_err   <= 1'b0;
          r_cpu_rdata <= r_c_wdata;
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack      = r_cpu_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_hit      = r_cpu_hit;
  assign cpu_err      = r_cpu_err;
  assign c_lookup     = (r_state == S_LOOKUP);
  assign c_addr       = r_addr;
  assign c_write      = r_c_write;
  assign c_fill       = (r_state == S_FILL);
  assign c_fill_dirty = (r_state == S_FILL) & r_wr;
  assign c_wdata      = r_c_wdata;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign n_hit        = r_n_hit;
  assign n_miss       = r_n_miss;
  assign n_wb         = r_n_wb;

endmodule

// File: tb/tb_controlador_cache.sv
// Directed bench for controlador_cache: the cache side is driven as static probe results, memory by a latency-programmable responder.
// Latencies are counted inclusively from the request cycle to the ack cycle.
// Responder acks after mem_lat cycles of mem_req, or never when disabled.
module tb_controlador_cache;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [3:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ack, cpu_hit, cpu_err;
  logic [7:0] cpu_rdata;
  logic       c_lookup, c_write, c_fill, c_fill_dirty;
  logic [3:0] c_addr;
  logic [7:0] c_wdata;
  logic       c_hit = 1'b0, c_vdirty = 1'b0;
  logic [7:0] c_rdata = '0, c_vdata = '0;
  logic [1:0] c_vtag = '0;
  logic       mem_req, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic [7:0] n_hit, n_miss, n_wb;

  controlador_cache dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .cpu_err(cpu_err),
    .c_lookup(c_lookup), .c_addr(c_addr), .c_hit(c_hit), .c_rdata(c_rdata),
    .c_vdirty(c_vdirty), .c_vtag(c_vtag), .c_vdata(c_vdata),
    .c_write(c_write), .c_fill(c_fill), .c_fill_dirty(c_fill_dirty), .c_wdata(c_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .n_hit(n_hit), .n_miss(n_miss), .n_wb(n_wb)
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder configuration (written by the stimulus only).
  logic       mem_en  = 1'b1;
  int         mem_lat = 0;
  logic [7:0] mem_val = '0;
  int         mem_cnt = 0;

  // Monitor state: cumulative counts plus last-seen values.
  int         cyc = 0, tot_reqcyc = 0, tot_wbcyc = 0, tot_fill = 0, tot_write = 0, tot_ack = 0;
  int         ack_at = 0, excl_err = 0;
  logic [3:0] wb_addr = '0, fe_addr = '0;
  logic [7:0] wb_data = '0, fill_data = '0, wr_data = '0, ack_rdata = '0;
  logic       fill_dirty = 1'b0, ack_hit = 1'b0, ack_err = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (mem_req) begin
      tot_reqcyc++;
      if (mem_we) begin tot_wbcyc++; wb_addr = mem_addr; wb_data = mem_wdata; end
      else fe_addr = mem_addr;
    end
    if (c_fill)  begin tot_fill++;  fill_data = c_wdata; fill_dirty = c_fill_dirty; end
    if (c_write) begin tot_write++; wr_data = c_wdata; end
    if (int'(c_lookup) + int'(c_write) + int'(c_fill) > 1) excl_err++;
    if (cpu_ack) begin tot_ack++; ack_at = cyc; ack_rdata = cpu_rdata; ack_hit = cpu_hit; ack_err = cpu_err; end
    // Responder: one-cycle ack after mem_lat cycles of request.
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req && mem_en) begin
      if (mem_cnt == mem_lat) begin mem_ack = 1'b1; mem_rdata = mem_val; mem_cnt = 0; end
      else mem_cnt++;
    end else if (!mem_req) mem_cnt = 0;
  end

  int lat, d_reqcyc, d_wbcyc, d_fill, d_write;

  task automatic do_req(input logic wr, input logic [3:0] addr, input logic [7:0] wd);
    int t0, b_req, b_wb, b_fill, b_wr, b_ack;
    logic done;
    @(posedge clock); #1;
    t0 = cyc; b_req = tot_reqcyc; b_wb = tot_wbcyc; b_fill = tot_fill; b_wr = tot_write; b_ack = tot_ack;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(posedge clock); #1;
      if (tot_ack != b_ack) done = 1'b1;
    end
    if (!done) check("ack_wait", 32'd0, 32'd1);
    lat = ack_at - t0;
    d_reqcyc = tot_reqcyc - b_req; d_wbcyc = tot_wbcyc - b_wb;
    d_fill = tot_fill - b_fill; d_write = tot_write - b_wr;
  endtask

  initial begin
    // Reset state
    #22;
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_c_lookup", c_lookup, 0);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_counters", {n_hit, n_miss, n_wb}, 24'h0);
    @(negedge clock); reset = 1'b1;

    // 1: clean read miss, memory acks after 2 wait cycles with A7
    c_hit = 0; c_vdirty = 0; mem_en = 1; mem_lat = 2; mem_val = 8'hA7;
    do_req(1'b0, 4'h5, 8'h00);
    check("t1_fetch_addr", fe_addr, 4'h5);
    check("t1_no_wb", d_wbcyc, 0);
    check("t1_fill_cnt", d_fill, 1);
    check("t1_fill_data", fill_data, 8'hA7);
    check("t1_fill_dirty", fill_dirty, 0);
    check("t1_rdata", ack_rdata, 8'hA7);
    check("t1_hit", ack_hit, 0);
    check("t1_err", ack_err, 0);
    check("t1_latency", lat, 7);
    check("t1_n_miss", n_miss, 8'd1);

    // 2: read hit
    c_hit = 1; c_rdata = 8'hA7;
    do_req(1'b0, 4'h5, 8'h00);
    check("t2_latency", lat, 3);
    check("t2_hit", ack_hit, 1);
    check("t2_rdata", ack_rdata, 8'hA7);
    check("t2_no_mem", d_reqcyc, 0);
    check("t2_n_hit", n_hit, 8'd1);

    // 3: write miss with dirty victim (tag 11, index 01 -> D)
    c_hit = 0; c_vdirty = 1; c_vtag = 2'b11; c_vdata = 8'h42; mem_lat = 1; mem_val = 8'h77;
    do_req(1'b1, 4'h9, 8'h3C);
    check("t3_wb_addr", wb_addr, 4'hD);
    check("t3_wb_data", wb_data, 8'h42);
    check("t3_fetch_addr", fe_addr, 4'h9);
    check("t3_fill_data", fill_data, 8'h3C);
    check("t3_fill_dirty", fill_dirty, 1);
    check("t3_rdata", ack_rdata, 8'h3C);
    check("t3_latency", lat, 9);
    check("t3_n_wb", n_wb, 8'd1);
    check("t3_n_miss", n_miss, 8'd2);

    // 4: write hit
    c_hit = 1; c_vdirty = 0;
    do_req(1'b1, 4'h2, 8'h11);
    check("t4_write_cnt", d_write, 1);
    check("t4_write_data", wr_data, 8'h11);
    check("t4_no_mem", d_reqcyc, 0);
    check("t4_rdata", ack_rdata, 8'h11);
    check("t4_n_hit", n_hit, 8'd2);

    // 5: memory never answers -> timeout
    c_hit = 0; mem_en = 0;
    do_req(1'b0, 4'h6, 8'h00);
    check("t5_req_cycles", d_reqcyc, 15);
    check("t5_err", ack_err, 1);
    check("t5_hit", ack_hit, 0);
    check("t5_no_fill", d_fill, 0);
    check("t5_latency", lat, 18);
    check("t5_req_low", mem_req, 0);

    // 6: reset during FETCH
    @(posedge clock); #1;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 4'h6;
    @(posedge clock); #1; cpu_req = 0;
    @(posedge clock); #1;
    check("t6_req_up", mem_req, 1);
    begin
      int b_ack;
      b_ack = tot_ack;
      #2 reset = 1'b0;
      #1;
      check("t6_req_drop", mem_req, 0);
      check("t6_counters", {n_hit, n_miss, n_wb}, 24'h0);
      check("t6_err_clr", cpu_err, 0);
      repeat (3) @(posedge clock);
      #3 reset = 1'b1;
      repeat (2) @(posedge clock);
      check("t6_no_ack", tot_ack - b_ack, 0);
    end
    mem_en = 1; mem_lat = 0; mem_val = 8'h5A;
    do_req(1'b0, 4'h6, 8'h00);
    check("t6_rdata", ack_rdata, 8'h5A);
    check("t6_err", ack_err, 0);
    check("t6_n_miss", n_miss, 8'd1);

    // 7: hit counter saturation
    c_hit = 1; c_rdata = 8'h00;
    for (int k = 0; k < 255; k++) do_req(1'b0, 4'h1, 8'h00);
    check("t7_n_hit_ff", n_hit, 8'hFF);
    do_req(1'b0, 4'h1, 8'h00);
    check("t7_n_hit_sat", n_hit, 8'hFF);
    check("t7_n_miss", n_miss, 8'd1);

    check("strobe_exclusive", excl_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
